// File: rtl/ti_share_wrapper.sv
// Host-side wrapper for threshold-implementation Simon cores. It masks one {key, pt}
// block into NSHARE Boolean shares, runs the shared core, and XOR-recombines the result.
module ti_share_wrapper #(
    parameter int          BW      = 128,
    parameter int          KW      = 128,
    parameter int          NSHARE  = 2,
    parameter logic [31:0] SEED    = 32'h1357_9BDF,
    parameter int          TIMEOUT = 4096
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         EN,
    input  logic                         Drdy,
    input  logic [BW+KW-1:0]             Din,
    output logic [BW-1:0]                Dout,
    output logic                         Dvld,
    output logic                         BSY,
    output logic                         Trig,
    output logic                         Err,
    output logic [NSHARE*(BW+KW)-1:0]    core_din,
    output logic                         core_drdy,
    input  logic [NSHARE*BW-1:0]         core_dout,
    input  logic                         core_dvld
);

    localparam int          SW       = BW + KW;
    localparam int          M        = (NSHARE - 1) * SW;
    localparam int          MASK_CYC = M / 32;
    localparam int          MCW      = $clog2(MASK_CYC + 1);
    localparam int          RCW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] POLY     = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, MASK, LAUNCH, RUN} state_t;

    state_t                  state;
    logic [MCW-1:0]          mask_cnt;
    logic [RCW-1:0]          run_cnt;
    logic [31:0]             lfsr;
    logic [SW-1:0]           data_reg;
    logic [M-1:0]            mask_sr;
    logic [NSHARE*SW-1:0]    shares;
    logic [BW-1:0]           recombined;
    logic                    accept;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    assign accept = (state == IDLE) && Drdy && EN;
    assign BSY    = (state != IDLE);

    // Share 0 absorbs the data; the random shares sit above it exactly as held in mask_sr.
    always_comb begin
        logic [SW-1:0] acc;
        acc = data_reg;
        for (int i = 1; i < NSHARE; i++) begin
            acc = acc ^ mask_sr[i*SW-1 -: SW];
        end
        shares = {mask_sr, acc};
    end

    always_comb begin
        recombined = '0;
        for (int i = 0; i < NSHARE; i++) begin
            recombined = recombined ^ core_dout[i*BW +: BW];
        end
    end

    // Captured block and mask shift register carry no reset; both are fully rewritten before use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            data_reg <= Din;
        end
        if (state == MASK && EN) begin
            mask_sr <= (mask_sr << 32) | M'(lfsr);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            mask_cnt  <= '0;
            run_cnt   <= '0;
            lfsr      <= SEED;
            Dout      <= '0;
            Dvld      <= 1'b0;
            Trig      <= 1'b0;
            Err       <= 1'b0;
            core_din  <= '0;
            core_drdy <= 1'b0;
        end else begin
            Dvld      <= 1'b0;
            core_drdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        Err      <= 1'b0;
                        mask_cnt <= MCW'(MASK_CYC - 1);
                        state    <= MASK;
                    end
                end
                MASK: begin
                    if (!EN) begin
                        state <= IDLE;
                    end else begin
                        lfsr <= lfsr_step(lfsr);
                        if (mask_cnt == '0) begin
                            state <= LAUNCH;
                        end else begin
                            mask_cnt <= mask_cnt - 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    if (!EN) begin
                        state <= IDLE;
                    end else begin
                        core_din  <= shares;
                        core_drdy <= 1'b1;
                        Trig      <= 1'b1;
                        run_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks a result; a result outranks the timeout.
                    if (!EN) begin
                        Trig  <= 1'b0;
                        state <= IDLE;
                    end else if (core_dvld) begin
                        Dout  <= recombined;
                        Dvld  <= 1'b1;
                        Trig  <= 1'b0;
                        state <= IDLE;
                    end else if (run_cnt == RCW'(TIMEOUT - 1)) begin
                        Err   <= 1'b1;
                        Trig  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ti_share_wrapper.sv
// Scoreboard bench for ti_share_wrapper: a 2-share instance (short timeout) and a 3-share
// instance, each with a stub core that echoes every share's plaintext after 10 cycles.
module tb_ti_share_wrapper;

    localparam int          BW   = 128;
    localparam int          KW   = 128;
    localparam int          SW   = BW + KW;
    localparam logic [31:0] SEED = 32'h1357_9BDF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int dvld_a = 0;
    int dvld_b = 0;

    // Instance A: NSHARE=2, TIMEOUT=32
    logic              rstn, en, drdy, silent;
    logic [SW-1:0]     din;
    logic [BW-1:0]     dout;
    logic              dvld, bsy, trig, err;
    logic [2*SW-1:0]   cdin;
    logic              cdrdy;
    logic [2*BW-1:0]   cdout;
    logic              cdvld;

    // Instance B: NSHARE=3, default TIMEOUT
    logic              rstn_b, en_b, drdy_b;
    logic [SW-1:0]     din_b;
    logic [BW-1:0]     dout_b;
    logic              dvld_b_o, bsy_b, trig_b, err_b;
    logic [3*SW-1:0]   cdin_b;
    logic              cdrdy_b;
    logic [3*BW-1:0]   cdout_b;
    logic              cdvld_b;

    ti_share_wrapper #(.NSHARE(2), .TIMEOUT(32)) dut (
        .CLK(clk), .RSTn(rstn), .EN(en), .Drdy(drdy), .Din(din),
        .Dout(dout), .Dvld(dvld), .BSY(bsy), .Trig(trig), .Err(err),
        .core_din(cdin), .core_drdy(cdrdy), .core_dout(cdout), .core_dvld(cdvld)
    );

    ti_share_wrapper #(.NSHARE(3)) dut_b (
        .CLK(clk), .RSTn(rstn_b), .EN(en_b), .Drdy(drdy_b), .Din(din_b),
        .Dout(dout_b), .Dvld(dvld_b_o), .BSY(bsy_b), .Trig(trig_b), .Err(err_b),
        .core_din(cdin_b), .core_drdy(cdrdy_b), .core_dout(cdout_b), .core_dvld(cdvld_b)
    );

    // Stub cores: latch shares on core_drdy, answer with each share's plaintext 10 cycles later.
    logic [2*SW-1:0] lat_a;
    int              cnt_a;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_a <= 0; cdvld <= 1'b0; lat_a <= '0;
        end else begin
            cdvld <= 1'b0;
            if (cdrdy && !silent) begin
                lat_a <= cdin; cnt_a <= 10;
            end else if (cnt_a == 1) begin
                cnt_a <= 0; cdvld <= 1'b1;
            end else if (cnt_a > 1) begin
                cnt_a <= cnt_a - 1;
            end
        end
    end
    always_comb begin
        cdout = '0;
        for (int i = 0; i < 2; i++) cdout[i*BW +: BW] = lat_a[i*SW +: BW];
    end

    logic [3*SW-1:0] lat_b;
    int              cnt_b;
    always @(posedge clk or negedge rstn_b) begin
        if (!rstn_b) begin
            cnt_b <= 0; cdvld_b <= 1'b0; lat_b <= '0;
        end else begin
            cdvld_b <= 1'b0;
            if (cdrdy_b) begin
                lat_b <= cdin_b; cnt_b <= 10;
            end else if (cnt_b == 1) begin
                cnt_b <= 0; cdvld_b <= 1'b1;
            end else if (cnt_b > 1) begin
                cnt_b <= cnt_b - 1;
            end
        end
    end
    always_comb begin
        cdout_b = '0;
        for (int i = 0; i < 3; i++) cdout_b[i*BW +: BW] = lat_b[i*SW +: BW];
    end

    // Reference model state
    logic [BW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    logic [31:0]   lm_a, lm_b;
    bit            lm_a_ok;
    logic [BW-1:0] last_pt;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [SW-1:0] rnd();
        logic [SW-1:0] r;
        for (int i = 0; i < SW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [SW-1:0] d, input bit resp);
        int k;
        logic [511:0] m;
        if (resp) qa.push_back(d[BW-1:0]);
        @(negedge clk); din = d; drdy = 1'b1;
        @(negedge clk); drdy = 1'b0;
        chk("a_bsy_accept", bsy, 1);
        chk("a_err_cleared", err, 0);
        k = 0;
        while (cdrdy !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("a_launch_latency", k, 9);
        chk("a_trig_launch", trig, 1);
        chk("a_share_xor", cdin[SW-1:0] ^ cdin[2*SW-1:SW], d);
        m = '0;
        for (int i = 0; i < 8; i++) begin m = (m << 32) | 512'(lm_a); lm_a = lstep(lm_a); end
        if (lm_a_ok) chk("a_share1_lfsr", cdin[2*SW-1:SW], m);
    endtask

    task automatic wait_done_a();
        int k;
        k = 0;
        while (bsy === 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("a_done_in_budget", k < 200, 1);
        @(negedge clk);
        chk("a_trig_idle", trig, 0);
    endtask

    task automatic send_b(input logic [SW-1:0] d);
        int k;
        logic [511:0] m;
        qb.push_back(d[BW-1:0]);
        @(negedge clk); din_b = d; drdy_b = 1'b1;
        @(negedge clk); drdy_b = 1'b0;
        k = 0;
        while (cdrdy_b !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("b_launch_latency", k, 17);
        chk("b_share_xor", cdin_b[SW-1:0] ^ cdin_b[2*SW-1:SW] ^ cdin_b[3*SW-1:2*SW], d);
        m = '0;
        for (int i = 0; i < 16; i++) begin m = (m << 32) | 512'(lm_b); lm_b = lstep(lm_b); end
        chk("b_share1_lfsr", cdin_b[2*SW-1:SW], m[255:0]);
        chk("b_share2_lfsr", cdin_b[3*SW-1:2*SW], m[511:256]);
        k = 0;
        while (bsy_b === 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("b_done_in_budget", k < 200, 1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] kat, r;
        int c0, k;
        kat = {128'h0f0e0d0c0b0a09080706050403020100, 128'h63736564207372656c6c657661727420};
        rstn = 1'b0; en = 1'b1; drdy = 1'b0; din = '0; silent = 1'b0;
        rstn_b = 1'b0; en_b = 1'b1; drdy_b = 1'b0; din_b = '0;
        lm_a = SEED; lm_a_ok = 1'b1; lm_b = SEED; last_pt = '0;

        fork
            forever begin
                @(negedge clk);
                if (dvld === 1'b1) begin
                    dvld_a++;
                    if (qa.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL a_unexpected_dvld: got Dout %0h, expected no output", dout);
                    end else begin
                        chk("a_dout", dout, qa.pop_front());
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (dvld_b_o === 1'b1) begin
                    dvld_b++;
                    if (qb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL b_unexpected_dvld: got Dout %0h, expected no output", dout_b);
                    end else begin
                        chk("b_dout", dout_b, qb.pop_front());
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_ctrl", {dvld, bsy, trig, err, cdrdy}, 0);
        chk("rst_core_din", cdin, 0);
        rstn = 1'b1; rstn_b = 1'b1;
        @(negedge clk);

        // Known-answer block, then the continued LFSR sequence on random blocks
        c0 = dvld_a;
        send_a(kat, 1'b1);
        wait_done_a();
        chk("a_kat_one_dvld", dvld_a - c0, 1);
        repeat (3) @(negedge clk);
        chk("a_dout_held", dout, 128'h63736564207372656c6c657661727420);
        last_pt = kat[BW-1:0];
        for (int n = 0; n < 3; n++) begin
            r = rnd();
            send_a(r, 1'b1);
            wait_done_a();
            last_pt = r[BW-1:0];
        end

        // Drdy pulsed while the core runs is dropped
        c0 = dvld_a;
        r = rnd();
        send_a(r, 1'b1);
        repeat (3) @(negedge clk);
        din = rnd(); drdy = 1'b1;
        @(negedge clk); drdy = 1'b0;
        wait_done_a();
        repeat (15) @(negedge clk);
        chk("a_drdy_in_run_one_dvld", dvld_a - c0, 1);
        chk("a_drdy_in_run_not_queued", bsy, 0);
        last_pt = r[BW-1:0];

        // EN dropped during MASK
        c0 = dvld_a;
        @(negedge clk); din = rnd(); drdy = 1'b1;
        @(negedge clk); drdy = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("a_abort_idle", bsy, 0);
        k = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (cdrdy) k++; end
        chk("a_abort_no_launch", k, 0);
        chk("a_abort_no_dvld", dvld_a - c0, 0);
        chk("a_abort_dout_kept", dout, last_pt);
        en = 1'b1;
        lm_a_ok = 1'b0;

        // Silent core: timeout sets Err after 32 RUN cycles
        c0 = dvld_a;
        silent = 1'b1;
        send_a(rnd(), 1'b0);
        k = 0;
        while (bsy === 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("a_timeout_cycles", k, 32);
        chk("a_timeout_err", err, 1);
        chk("a_timeout_trig", trig, 0);
        chk("a_timeout_dout_kept", dout, last_pt);
        chk("a_timeout_no_dvld", dvld_a - c0, 0);
        silent = 1'b0;
        r = rnd();
        send_a(r, 1'b1);
        wait_done_a();
        last_pt = r[BW-1:0];

        // Reset while in RUN
        send_a(rnd(), 1'b1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rstrun_dout", dout, 0);
        chk("rstrun_ctrl", {dvld, bsy, trig, err, cdrdy}, 0);
        chk("rstrun_core_din", cdin, 0);
        qa.delete();
        lm_a = SEED; lm_a_ok = 1'b1;
        @(negedge clk); rstn = 1'b1;
        c0 = dvld_a;
        send_a(rnd(), 1'b1);
        wait_done_a();
        chk("a_after_reset_one_dvld", dvld_a - c0, 1);

        // Three-share instance
        send_b(kat);
        for (int n = 0; n < 3; n++) send_b(rnd());
        chk("b_dvld_count", dvld_b, 4);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
